// File: rtl/execute_cycle_pkg.sv
// Shared pipeline constants for the execute stage, control unit and hazard unit.
//   - ALU operation codes (4 bit)
//   - forwarding select codes (2 bit)
//   - branch funct3 codes (3 bit)
//   - EX/MEM register payload struct
package execute_cycle_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
  } ex_mem_t;

  // Operand forwarding select; the unused code 11 falls back to the register file.
  function automatic logic [31:0] fwd_sel(input logic [1:0]  code,
                                          input logic [31:0] rf,
                                          input logic [31:0] wb,
                                          input logic [31:0] mem);
    case (code)
      FWD_WB:  return wb;
      FWD_MEM: return mem;
      default: return rf;
    endcase
  endfunction

endpackage

// File: rtl/execute_cycle_alu.sv
// 32-bit integer ALU for the execute stage.
//   SrcA, SrcB  in  32  operands
//   ALUControl  in  4   operation code (see execute_cycle_pkg)
//   Result      out 32  combinational result; undefined codes give 0
module alu
  import execute_cycle_pkg::*;
(
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [3:0]  ALUControl,
  output logic [31:0] Result
);

  logic [4:0] shamt;
  assign shamt = SrcB[4:0];

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD:   Result = SrcA + SrcB;
      ALU_SUB:   Result = SrcA - SrcB;
      ALU_AND:   Result = SrcA & SrcB;
      ALU_OR:    Result = SrcA | SrcB;
      ALU_XOR:   Result = SrcA ^ SrcB;
      ALU_SLT:   Result = {31'b0, $signed(SrcA) < $signed(SrcB)};
      ALU_SLTU:  Result = {31'b0, SrcA < SrcB};
      ALU_SLL:   Result = SrcA << shamt;
      ALU_SRL:   Result = SrcA >> shamt;
      ALU_SRA:   Result = $unsigned($signed(SrcA) >>> shamt);
      ALU_PASSB: Result = SrcB;
      default:   Result = '0;
    endcase
  end

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of a 5-stage RISC-V style pipeline.
//   clk, rst          clock, asynchronous active-low reset
//   *E inputs         ID/EX control and data
//   ForwardAE/BE      operand forwarding selects from the hazard unit
//   ResultW           writeback-stage result for forwarding
//   PCSrcE/PCTargetE  combinational redirect to fetch
//   *M outputs        EX/MEM pipeline register (ALUResultM also feeds forwarding)
module execute_cycle
  import execute_cycle_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic [1:0]  ResultSrcE,
  input  logic [3:0]  ALUControlE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [2:0]  funct3M,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] SrcAE, SrcBE, WriteDataE, ALUResultE;
  logic        cond;
  ex_mem_t     ex_e, ex_m;

  // Forwarding taps the registered EX/MEM result, never the live ALU output.
  assign SrcAE      = fwd_sel(ForwardAE, RD1_E, ResultW, ALUResultM);
  assign WriteDataE = fwd_sel(ForwardBE, RD2_E, ResultW, ALUResultM);
  assign SrcBE      = ALUSrcE ? Imm_Ext_E : WriteDataE;

  alu u_alu (
    .SrcA       (SrcAE),
    .SrcB       (SrcBE),
    .ALUControl (ALUControlE),
    .Result     (ALUResultE)
  );

  // Branches compare the two register operands, not the immediate-muxed SrcB.
  always_comb begin
    cond = 1'b0;
    case (funct3E)
      BR_EQ:   cond = (SrcAE == WriteDataE);
      BR_NE:   cond = (SrcAE != WriteDataE);
      BR_LT:   cond = ($signed(SrcAE) <  $signed(WriteDataE));
      BR_GE:   cond = ($signed(SrcAE) >= $signed(WriteDataE));
      BR_LTU:  cond = (SrcAE <  WriteDataE);
      BR_GEU:  cond = (SrcAE >= WriteDataE);
      default: cond = 1'b0;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & cond);
  assign PCTargetE = PCE + Imm_Ext_E;

  always_comb begin
    ex_e            = '0;
    ex_e.reg_write  = RegWriteE;
    ex_e.mem_write  = MemWriteE;
    ex_e.result_src = ResultSrcE;
    ex_e.funct3     = funct3E;
    ex_e.rd         = RD_E;
    ex_e.alu_result = ALUResultE;
    ex_e.write_data = WriteDataE;
    ex_e.pc_plus4   = PCPlus4E;
  end

  // No stall or flush here; bubbles are inserted upstream in ID/EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_m <= '0;
    else      ex_m <= ex_e;
  end

  assign RegWriteM  = ex_m.reg_write;
  assign MemWriteM  = ex_m.mem_write;
  assign ResultSrcM = ex_m.result_src;
  assign funct3M    = ex_m.funct3;
  assign RD_M       = ex_m.rd;
  assign ALUResultM = ex_m.alu_result;
  assign WriteDataM = ex_m.write_data;
  assign PCPlus4M   = ex_m.pc_plus4;

endmodule

// File: tb/tb_execute_cycle.sv
// Scoreboard bench for execute_cycle: the driver issues one instruction per
// cycle, checks the combinational redirect, and queues the expected EX/MEM
// contents; a monitor pops and compares after each rising edge.
module tb_execute_cycle;

  logic        clk, rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  funct3E;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .funct3E(funct3E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .funct3M(funct3M), .RD_M(RD_M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ctl;   // {RegWrite, MemWrite, ResultSrc, funct3, rd}
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_alu_m;   // reference copy of the registered ALU result
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU written from the opcode table.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    longint sa, sb2;
    sh  = b % 32;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = (sa < sb2) ? 32'd1 : 32'd0;
      4'd6:  r = ({32'b0, a} < {32'b0, b}) ? 32'd1 : 32'd0;
      4'd7:  r = a << sh;
      4'd8:  r = a >> sh;
      4'd9:  begin
               r = a >> sh;
               if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
             end
      4'd10: r = b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    longint sa, sb2, ua, ub;
    sa = longint'($signed(a)); sb2 = longint'($signed(b));
    ua = longint'({32'b0, a}); ub  = longint'({32'b0, b});
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa <  sb2;
      3'd5: return sa >= sb2;
      3'd6: return ua <  ub;
      3'd7: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [1:0] c, input logic [31:0] rf);
    if (c == 2'd1) return ResultW;
    if (c == 2'd2) return model_alu_m;
    return rf;
  endfunction

  task automatic bubble();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0;
    ResultSrcE = 0; ALUControlE = 0; funct3E = 0;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0;
    ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  // Called at a falling edge with inputs already set: checks the redirect,
  // queues the expected capture, then advances to the next falling edge.
  task automatic step();
    logic [31:0] a, wd, b, res;
    exp_t e;
    #1;
    a   = ref_fwd(ForwardAE, RD1_E);
    wd  = ref_fwd(ForwardBE, RD2_E);
    b   = ALUSrcE ? Imm_Ext_E : wd;
    res = ref_alu(ALUControlE, a, b);
    chk("PCSrcE", {31'b0, PCSrcE}, {31'b0, JumpE | (BranchE & ref_cond(funct3E, a, wd))});
    chk("PCTargetE", PCTargetE, PCE + Imm_Ext_E);
    e.ctl = {RegWriteE, MemWriteE, ResultSrcE, funct3E, RD_E};
    e.alu = res; e.wd = wd; e.pc4 = PCPlus4E;
    sb.push_back(e);
    model_alu_m = res;
    @(negedge clk);
  endtask

  // Monitor: each captured instruction appears on the M outputs after the edge.
  always @(posedge clk) begin
    #1;
    if (rst && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("M_ctl", {20'b0, RegWriteM, MemWriteM, ResultSrcM, funct3M, RD_M}, {20'b0, e.ctl});
      chk("ALUResultM", ALUResultM, e.alu);
      chk("WriteDataM", WriteDataM, e.wd);
      chk("PCPlus4M", PCPlus4M, e.pc4);
    end
  end

  task automatic set_alu(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic src, input logic [31:0] imm);
    bubble();
    ALUControlE = op; RD1_E = a; RD2_E = b; ALUSrcE = src; Imm_Ext_E = imm;
    RegWriteE = 1; RD_E = 5'd1;
  endtask

  task automatic check_m_zero(input string tag);
    chk({tag, "_RegWriteM"}, {31'b0, RegWriteM}, 32'd0);
    chk({tag, "_MemWriteM"}, {31'b0, MemWriteM}, 32'd0);
    chk({tag, "_ALUResultM"}, ALUResultM, 32'd0);
    chk({tag, "_others"}, {15'b0, ResultSrcM, funct3M, RD_M, 7'b0} | WriteDataM | PCPlus4M, 32'd0);
  endtask

  initial begin
    model_alu_m = 0;
    bubble();
    rst = 0;
    #3;
    check_m_zero("reset");
    @(negedge clk);
    rst = 1;

    // ADD with immediate
    bubble();
    RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1; ALUControlE = 4'b0000; RD_E = 3; RegWriteE = 1;
    step();
    // SUB forwarding from MEM (12 - 2), then from WB (40 - 2)
    set_alu(4'b0001, 0, 2, 0, 0); ForwardAE = 2'b10; step();
    set_alu(4'b0001, 0, 2, 0, 0); ForwardAE = 2'b01; ResultW = 40; step();
    // Forward code 11 falls back to register file operands
    set_alu(4'b0000, 32'h11, 32'h22, 0, 0); ForwardAE = 2'b11; ForwardBE = 2'b11;
    ResultW = 32'hDEAD; step();
    // Branches: signed lt taken, unsigned lt not taken, reserved funct3
    bubble(); BranchE = 1; funct3E = 3'b100; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
    PCE = 32'h100; Imm_Ext_E = 32'hFFFF_FFF8; step();
    funct3E = 3'b110; step();
    funct3E = 3'b010; RD2_E = 32'hFFFF_FFFF; step();
    bubble(); JumpE = 1; PCE = 32'hFFFF_FFFC; Imm_Ext_E = 8; step();
    // Shifts use SrcB[4:0] only; undefined opcode yields 0
    set_alu(4'b1001, 32'h8000_0000, 0, 1, 32'h21); step();
    set_alu(4'b1000, 32'h8000_0000, 0, 1, 32'h21); step();
    set_alu(4'b1111, 32'h1234_5678, 0, 1, 32'h9); step();
    // Bubble must not write
    bubble(); step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) bubble();
      else begin
        RegWriteE = 1'($urandom); ALUSrcE = 1'($urandom); MemWriteE = 1'($urandom);
        BranchE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
        ResultSrcE = 2'($urandom); ALUControlE = 4'($urandom); funct3E = 3'($urandom);
        RD1_E = $urandom; RD2_E = ($urandom_range(0, 3) == 0) ? RD1_E : $urandom;
        Imm_Ext_E = $urandom; PCE = $urandom; PCPlus4E = PCE + 4; RD_E = 5'($urandom);
        ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
      end
      step();
    end

    // Mid-operation reset: valid store in flight, reset between edges
    set_alu(4'b0000, 32'h55, 32'h66, 0, 0); MemWriteE = 1; step();
    set_alu(4'b0000, 32'h77, 32'h88, 0, 0); MemWriteE = 1;
    #2;
    rst = 0;
    sb.delete();
    model_alu_m = 0;
    #1;
    check_m_zero("async_rst");
    PCE = 32'h2000; Imm_Ext_E = 32'h40;
    #1;
    chk("PCTarget_in_rst", PCTargetE, 32'h2040);
    @(posedge clk); #1;
    check_m_zero("rst_held");
    @(negedge clk);
    rst = 1;
    set_alu(4'b0010, 32'hF0F0, 32'hFF00, 0, 0); MemWriteE = 1; step();
    bubble(); step();
    bubble(); step();

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst (active-low, asynchronous).
REQ-002 clk  input  1  pipeline clock.
REQ-003 rst  input  1  async active-low reset.
REQ-004 RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE  input  1 each  ID/EX control.
REQ-005 ResultSrcE  input  2; ALUControlE  input  4; funct3E  input  3  ID/EX control.
REQ-006 RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  input  32 each  ID/EX data.
REQ-007 RD_E  input  5  destination register.
REQ-008 ForwardAE, ForwardBE  input  2 each  operand-select codes from the hazard unit.
REQ-009 ResultW  input  32  writeback result; ALUResultM  output/feedback  32  EX/MEM ALU result.
REQ-010 PCSrcE  output  1; PCTargetE  output  32  combinational redirect to fetch.
REQ-011 RegWriteM, MemWriteM  output  1 each; ResultSrcM  output  2; funct3M  output  3; RD_M  output  5; WriteDataM, PCPlus4M  output  32 each  EX/MEM register.

Function
REQ-012 SrcAE SHALL be RD1_E/ResultW/ALUResultM for ForwardAE 00/01/10; code 11 SHALL select RD1_E.
REQ-013 WriteDataE SHALL be RD2_E/ResultW/ALUResultM for ForwardBE 00/01/10; code 11 SHALL select RD2_E.
REQ-014 SrcBE SHALL be Imm_Ext_E when ALUSrcE=1, else WriteDataE.
REQ-015 ALU encoding SHALL be: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASSB.
REQ-016 Codes 1011-1111 SHALL produce a result of 0.
REQ-017 Add and sub SHALL wrap modulo 2^32; shifts SHALL use SrcBE[4:0] only; SLT/SLTU SHALL return 32'h1 or 32'h0.
REQ-018 The branch condition SHALL use SrcAE vs WriteDataE by funct3E: 000 eq, 001 ne, 100 lt signed, 101 ge signed, 110 lt unsigned, 111 ge unsigned.
REQ-019 Other funct3E values SHALL make the branch condition false.
REQ-020 PCSrcE SHALL be JumpE | (BranchE & condition); PCTargetE SHALL be PCE + Imm_Ext_E, wrapping modulo 2^32.
REQ-021 PCSrcE and PCTargetE SHALL be purely combinational, with zero-cycle latency.
REQ-022 The EX/MEM register SHALL capture on every rising clk: RegWriteE, MemWriteE, ResultSrcE, funct3E, RD_E, ALU result, WriteDataE and PCPlus4E.
REQ-023 Latency from E inputs to M outputs SHALL be exactly 1 cycle; the register has no stall or flush (flushing is done in ID/EX).
REQ-024 ALUResultM SHALL feed back to the forwarding muxes as the registered value, not the current ALU output.
REQ-025 A bubble input (all controls 0, data 0) SHALL yield RegWriteM=0 and MemWriteM=0 on the next cycle.

Reset
REQ-026 While rst=0, every M output SHALL be 0 immediately, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight instruction.
REQ-028 The first capture after rst rises SHALL occur on the next rising clk.
REQ-029 PCSrcE and PCTargetE SHALL follow their inputs during reset, since they are combinational.

Structure
REQ-030 ALU opcodes, forward codes (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and branch funct3 constants SHALL live in a shared pipeline package, also used by the control and hazard units.
REQ-031 The ALU SHALL be one sub-module, alu (SrcA, SrcB, ALUControl -> Result), instantiated once.
REQ-032 The forwarding muxes, branch comparator and EX/MEM register SHALL be inline.

Verification
REQ-033 ADD: RD1_E=5, Imm_Ext_E=7, ALUSrcE=1, ALUControlE=0000, RD_E=3, RegWriteE=1 -> next cycle ALUResultM=12, RD_M=3, RegWriteM=1.
REQ-034 Forwarding: the prior instruction left ALUResultM=12, ForwardAE=10, RD1_E=0, SUB with RD2_E=2 -> ALUResult 10; then ForwardAE=01 with ResultW=40 -> 38.
REQ-035 Branch: BranchE=1, funct3E=100, SrcAE=32'hFFFFFFFF, WriteDataE=1 -> PCSrcE=1; funct3E=110 with the same operands -> PCSrcE=0; PCE=0x100, Imm=-8 -> PCTargetE=0xF8.
REQ-036 Shifts: SRA of 0x80000000 by SrcBE=0x21 -> 0xC0000000; SRL by the same amount -> 0x40000000; ALUControlE=1111 -> 0.
REQ-037 Reset: drive valid stores, assert rst=0 between clock edges -> MemWriteM, RegWriteM and ALUResultM go to 0 at once; release -> capture resumes on the next edge.
